// File: rtl/serial_cmd_if.sv
// Byte handshake bundle between the serial command responder and the
// deserializer (RX side) / serializer (TX side).
//   rx_data/rx_req : byte offered by the deserializer
//   rx_ack         : byte taken by the responder
//   tx_data/tx_req : byte offered by the responder
//   tx_ack         : byte taken by the serializer
// The slave modport is the responder view; master is the serial-port view.
interface serial_cmd_if;
    logic [7:0] rx_data;
    logic       rx_req;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ack;

    modport slave (
        input  rx_data,
        input  rx_req,
        output rx_ack,
        output tx_data,
        output tx_req,
        input  tx_ack
    );

    modport master (
        output rx_data,
        output rx_req,
        input  rx_ack,
        input  tx_data,
        input  tx_req,
        output tx_ack
    );
endinterface

// File: rtl/serial_cmd_responder.sv
// ASCII register-access responder.
// Parses "W a dd CR" and "R a CR" commands arriving as bytes on the RX handshake,
// executes them on a 16 x 8-bit register file and answers over the TX handshake
// with "K\r\n", "<hh>\r\n" or "E\r\n".
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : RX/TX 4-phase byte handshakes (slave modport)
//   regs_out    : register file, reg[n] = regs_out[8n+7:8n]
//   wr_strobe   : one-cycle pulse on each register write
//   wr_addr     : address of the last write
module serial_cmd_responder #(
    parameter int unsigned P_TIMEOUT_CYCLES = 100000000,
    parameter logic [7:0]  P_REG_RESET      = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_cmd_if.slave   bus,
    output logic [127:0]  regs_out,
    output logic          wr_strobe,
    output logic [3:0]    wr_addr
);

    localparam int unsigned TO_W = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(P_TIMEOUT_CYCLES - 1);

    localparam logic [7:0] C_CR = 8'h0D;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_K  = 8'h4B;
    localparam logic [7:0] C_E  = 8'h45;
    localparam logic [7:0] C_W  = 8'h57;
    localparam logic [7:0] C_R  = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_D1,
        S_W_D0,
        S_W_CR,
        S_R_ADDR,
        S_R_CR,
        S_SEND
    } state_t;

    // ASCII hex digit -> {valid, nibble}; accepts 0-9, A-F, a-f
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] res;
        res = 5'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            res = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            res = {1'b1, c[3:0] + 4'd9};
        end
        return res;
    endfunction

    // Nibble -> uppercase ASCII hex digit
    function automatic logic [7:0] hex_encode(input logic [3:0] n);
        logic [7:0] res;
        if (n < 4'd10) begin
            res = 8'h30 + {4'h0, n};
        end else begin
            res = 8'h37 + {4'h0, n};
        end
        return res;
    endfunction

    state_t              r_state,    w_state;
    logic                r_rx_ack,   w_rx_ack;
    logic                r_rx_armed, w_rx_armed;
    logic                r_tx_req,   w_tx_req;
    logic [7:0]          r_tx_data,  w_tx_data;
    logic [3:0][7:0]     r_buf,      w_buf;
    logic [1:0]          r_idx,      w_idx;
    logic [1:0]          r_last,     w_last;
    logic [3:0]          r_addr,     w_addr;
    logic [7:0]          r_data,     w_data;
    logic [15:0][7:0]    r_regs,     w_regs;
    logic                r_wr_strobe, w_wr_strobe;
    logic [3:0]          r_wr_addr,  w_wr_addr;
    logic [TO_W-1:0]     r_to_cnt,   w_to_cnt;

    logic                w_accept;
    logic                w_counting;
    logic [4:0]          w_hex;
    logic                w_is_hex;
    logic [3:0]          w_nib;
    logic [7:0]          w_upper;
    logic                w_is_cr;
    logic                w_is_lf;

    // A byte is taken only in a parse state, once per rx_req low->high cycle
    assign w_accept   = (r_state != S_SEND) && bus.rx_req && !r_rx_ack && r_rx_armed;
    assign w_counting = (r_state != S_IDLE) && (r_state != S_SEND);
    assign w_hex      = hex_decode(bus.rx_data);
    assign w_is_hex   = w_hex[4];
    assign w_nib      = w_hex[3:0];
    // Clearing bit 5 folds lowercase letters onto uppercase; only used for W/R compare
    assign w_upper    = bus.rx_data & 8'hDF;
    assign w_is_cr    = (bus.rx_data == C_CR);
    assign w_is_lf    = (bus.rx_data == C_LF);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rx_ack    <= 1'b0;
            r_rx_armed  <= 1'b1;
            r_tx_req    <= 1'b0;
            r_tx_data   <= 8'h00;
            r_buf       <= '0;
            r_idx       <= 2'd0;
            r_last      <= 2'd0;
            r_addr      <= 4'h0;
            r_data      <= 8'h00;
            r_regs      <= {16{P_REG_RESET}};
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 4'h0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state;
            r_rx_ack    <= w_rx_ack;
            r_rx_armed  <= w_rx_armed;
            r_tx_req    <= w_tx_req;
            r_tx_data   <= w_tx_data;
            r_buf       <= w_buf;
            r_idx       <= w_idx;
            r_last      <= w_last;
            r_addr      <= w_addr;
            r_data      <= w_data;
            r_regs      <= w_regs;
            r_wr_strobe <= w_wr_strobe;
            r_wr_addr   <= w_wr_addr;
            r_to_cnt    <= w_to_cnt;
        end
    end

    // Next-state: command parser, reply sender, timeout
    always_comb begin
        w_state     = r_state;
        w_rx_ack    = 1'b0;
        w_rx_armed  = r_rx_armed;
        w_tx_req    = r_tx_req;
        w_tx_data   = r_tx_data;
        w_buf       = r_buf;
        w_idx       = r_idx;
        w_last      = r_last;
        w_addr      = r_addr;
        w_data      = r_data;
        w_regs      = r_regs;
        w_wr_strobe = 1'b0;
        w_wr_addr   = r_wr_addr;
        w_to_cnt    = r_to_cnt;

        if (!bus.rx_req) begin
            w_rx_armed = 1'b1;
        end

        if (w_accept) begin
            w_rx_ack   = 1'b1;
            w_rx_armed = 1'b0;
            w_to_cnt   = '0;
            // Error reply unless a branch below claims the byte
            w_state    = S_SEND;
            w_buf      = {8'h00, C_LF, C_CR, C_E};
            w_idx      = 2'd0;
            w_last     = 2'd2;
            case (r_state)
                S_IDLE: begin
                    if (w_upper == C_W) begin
                        w_state = S_W_ADDR;
                    end else if (w_upper == C_R) begin
                        w_state = S_R_ADDR;
                    end else if (w_is_cr || w_is_lf) begin
                        w_state = S_IDLE;
                    end
                end
                S_W_ADDR: begin
                    if (w_is_hex) begin
                        w_addr  = w_nib;
                        w_state = S_W_D1;
                    end
                end
                S_W_D1: begin
                    if (w_is_hex) begin
                        w_data  = {w_nib, 4'h0};
                        w_state = S_W_D0;
                    end
                end
                S_W_D0: begin
                    if (w_is_hex) begin
                        w_data  = {r_data[7:4], w_nib};
                        w_state = S_W_CR;
                    end
                end
                S_W_CR: begin
                    if (w_is_cr) begin
                        w_regs[r_addr] = r_data;
                        w_wr_strobe    = 1'b1;
                        w_wr_addr      = r_addr;
                        w_buf          = {8'h00, C_LF, C_CR, C_K};
                    end
                end
                S_R_ADDR: begin
                    if (w_is_hex) begin
                        w_addr  = w_nib;
                        w_state = S_R_CR;
                    end
                end
                S_R_CR: begin
                    if (w_is_cr) begin
                        // Snapshot taken here so later writes cannot alter this reply
                        w_buf  = {C_LF, C_CR,
                                  hex_encode(r_regs[r_addr][3:0]),
                                  hex_encode(r_regs[r_addr][7:4])};
                        w_last = 2'd3;
                    end
                end
                default: ;
            endcase
        end else if (r_state == S_SEND) begin
            if (!r_tx_req) begin
                // Present next byte only once the previous ack has returned low
                if (!bus.tx_ack) begin
                    w_tx_req  = 1'b1;
                    w_tx_data = r_buf[r_idx];
                end
            end else if (bus.tx_ack) begin
                w_tx_req = 1'b0;
                if (r_idx == r_last) begin
                    w_state = S_IDLE;
                    w_idx   = 2'd0;
                end else begin
                    w_idx = r_idx + 2'd1;
                end
            end
        end else if (w_counting && (P_TIMEOUT_CYCLES != 0)) begin
            if (r_to_cnt == TO_LAST) begin
                w_state  = S_IDLE;
                w_to_cnt = '0;
            end else begin
                w_to_cnt = r_to_cnt + TO_W'(1);
            end
        end else begin
            w_to_cnt = '0;
        end
    end

    assign bus.rx_ack  = r_rx_ack;
    assign bus.tx_req  = r_tx_req;
    assign bus.tx_data = r_tx_data;
    assign regs_out    = r_regs;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;

endmodule
